// File: rtl/corner_pkg.sv
// corner_pkg: shared word formats, tags and FSM states for the corner AXI-Stream packer.
package corner_pkg;
  localparam logic [3:0] TAG_CORNER  = 4'hC;
  localparam logic [3:0] TAG_TRAILER = 4'hF;
  localparam int DATA_W = 32;
  localparam int WORD_W = DATA_W + 1;
  typedef enum logic {S_RUN, S_PEND} state_t;
  function automatic logic [DATA_W-1:0] pack_corner(input logic [9:0] x, input logic [9:0] y);
    return {TAG_CORNER, 8'h00, y, x};
  endfunction
  function automatic logic [DATA_W-1:0] pack_trailer(input logic drop, input logic [19:0] cnt);
    return {TAG_TRAILER, drop, 7'h00, cnt};
  endfunction
endpackage

// File: rtl/corner_fifo.sv
// corner_fifo: synchronous first-word-fall-through FIFO with occupancy output.
module corner_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 33,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  logic wr, rd;
  assign wr    = wr_en & !full;
  assign rd    = rd_en & !empty;
  assign full  = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout  = mem[rp_q];
  always_ff @(posedge clk)
    if (wr) mem[wp_q] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(wr);
      rp_q    <= rp_q + AW'(rd);
      level_q <= level_q + LW'(wr) - LW'(rd);
    end
endmodule

// File: rtl/corner_axis_packer.sv
// corner_axis_packer: packs NMS corners into 32-bit AXI-Stream words and appends a
// per-frame trailer carrying the corner count, buffered through a FIFO.
module corner_axis_packer
  import corner_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int COORD_W    = 10,
  parameter int CNT_W      = 20,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               iscorner,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  input  logic               frame_eof,
  output logic [31:0]        m_axis_tdata,
  output logic [3:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [LW-1:0]      fifo_level,
  output logic               overflow
);
  state_t st_q, st_d;
  logic [WORD_W-1:0] pend_q, pend_d, din, dout, trl;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic drop_q, drop_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic corner_in, eof_in, wr_corner, drop, wr_trl, to_pend, wr_pend, eof_gen;
  logic wr_en, rd_en, full, empty;
  assign corner_in = ce & iscorner;
  assign eof_in    = ce & frame_eof;
  always_comb begin
    wr_corner = st_q == S_RUN && corner_in && fifo_level < LW'(FIFO_DEPTH - 1);
    drop      = corner_in & !wr_corner;
    cnt_inc   = (wr_corner && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    trl       = {1'b1, pack_trailer(drop_q | drop, 20'(cnt_inc))};
    wr_trl    = st_q == S_RUN && eof_in && !corner_in && !full;
    // A same-cycle corner occupies the write port, so its trailer waits one cycle in pend.
    to_pend   = st_q == S_RUN && eof_in && (corner_in || full);
    wr_pend   = st_q == S_PEND && !full;
    eof_gen   = wr_trl | to_pend;
    wr_en     = wr_corner | wr_trl | wr_pend;
    din       = wr_pend ? pend_q : wr_trl ? trl : {1'b0, pack_corner(10'(x_coord), 10'(y_coord))};
    pend_d    = to_pend ? trl : pend_q;
    st_d      = to_pend ? S_PEND : wr_pend ? S_RUN : st_q;
    cnt_d     = eof_gen ? '0 : cnt_inc;
    drop_d    = eof_gen ? 1'b0 : drop_q | drop;
    ovf_d     = ovf_q | drop;
    rd_en     = (!tvalid_q || m_axis_tready) && !empty;
    tvalid_d  = rd_en | (tvalid_q & !m_axis_tready);
    tdata_d   = rd_en ? dout[DATA_W-1:0] : tdata_q;
    tlast_d   = rd_en ? dout[DATA_W] : tlast_q;
  end
  corner_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W), .LW(LW)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .level(fifo_level)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q     <= S_RUN;
      pend_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_corner_axis_packer.sv
// tb_corner_axis_packer: directed checks of corner packing, trailers, back-pressure and reset.
module tb_corner_axis_packer;
  logic clk = 0, rst = 0, ce = 0, iscorner = 0, frame_eof = 0, m_axis_tready = 0;
  logic [9:0] x_coord = 0, y_coord = 0;
  logic [31:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid, overflow;
  logic [6:0] fifo_level;
  int n_checks = 0, n_fail = 0;
  logic [31:0] d;
  logic l;
  always #5 clk = ~clk;
  corner_axis_packer dut (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner), .x_coord(x_coord), .y_coord(y_coord),
    .frame_eof(frame_eof), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [32:0] exp_corner(input int x, input int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    return {1'b0, 4'hC, 8'h00, ys, xs};
  endfunction
  task automatic send(input int x, input int y, input logic c, input logic e);
    @(negedge clk);
    ce = 1; iscorner = c; frame_eof = e; x_coord = x[9:0]; y_coord = y[9:0];
  endtask
  task automatic idle();
    @(negedge clk);
    ce = 0; iscorner = 0; frame_eof = 0;
  endtask
  task automatic pop(input int stall, output logic [31:0] pd, output logic pl);
    int t = 0;
    while (!m_axis_tvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!m_axis_tvalid) check("pop_timeout", m_axis_tvalid, 1);
    pd = m_axis_tdata;
    pl = m_axis_tlast;
    repeat (stall) @(negedge clk);
    if (stall > 0) check("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, pl, pd});
    m_axis_tready = 1;
    @(negedge clk);
    m_axis_tready = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tkeep", m_axis_tkeep, 4'hF);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    rst = 1;
    // Test 1: three corners then eof; trailer is left stalled in the output register
    send(5, 7, 1, 0); send(639, 0, 1, 0); send(0, 479, 1, 0); send(0, 0, 0, 1); idle();
    repeat (3) @(negedge clk);
    pop(0, d, l); check("t1_w0", {l, d}, 33'h0_C0001C05);
    pop(0, d, l); check("t1_w1", {l, d}, 33'h0_C000027F);
    pop(0, d, l); check("t1_w2", {l, d}, 33'h0_C0077C00);
    check("t1_trl", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b11, 32'hF0000003});
    // Test 2: 70 corners with tready low; only 63 fit beside the trailer slot
    for (int i = 0; i < 70; i++) send(i, 0, 1, 0);
    send(0, 0, 0, 1); idle();
    repeat (25) @(negedge clk);
    check("t2_level", fifo_level, 64);
    check("t2_ovf", overflow, 1);
    check("t2_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b11, 32'hF0000003});
    pop(0, d, l); check("t2_prev_trl", {l, d}, 33'h1_F0000003);
    for (int i = 0; i < 63; i++) begin
      pop(0, d, l); check($sformatf("t2_w%0d", i), {l, d}, exp_corner(i, 0));
    end
    pop(0, d, l); check("t2_trl", {l, d}, 33'h1_F800003F);
    check("t2_empty", fifo_level, 0);
    // Test 3: corner and eof in the same cycle
    send(1, 1, 1, 0); send(2, 2, 1, 1); idle();
    pop(0, d, l); check("t3_w0", {l, d}, 33'h0_C0000401);
    pop(0, d, l); check("t3_w1", {l, d}, 33'h0_C0000802);
    pop(0, d, l); check("t3_trl", {l, d}, 33'h1_F0000002);
    // Test 4: 1000-corner frame with random back-pressure
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(i % 640, i / 640, 1, 0);
          repeat (3) idle();
        end
        send(0, 0, 0, 1); idle();
      end
      begin
        logic [31:0] cd;
        logic cl;
        for (int i = 0; i < 1000; i++) begin
          pop($urandom_range(0, 2), cd, cl);
          check($sformatf("t4_w%0d", i), {cl, cd}, exp_corner(i % 640, i / 640));
        end
        pop($urandom_range(0, 2), cd, cl);
        check("t4_trl", {cl, cd}, 33'h1_F00003E8);
      end
    join
    // Test 5: reset with words queued, then first-word latency
    for (int i = 0; i < 10; i++) send(100 + i, 0, 1, 0);
    idle(); idle();
    check("t5_pre_valid", m_axis_tvalid, 1);
    check("t5_pre_level", fifo_level, 9);
    #2 rst = 0;
    #1;
    check("t5_rst_valid", m_axis_tvalid, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_ovf", overflow, 0);
    @(negedge clk) rst = 1;
    send(3, 4, 1, 0); idle();
    check("t5_lat_n1", m_axis_tvalid, 0);
    @(negedge clk);
    check("t5_lat_n2", m_axis_tvalid, 1);
    pop(0, d, l); check("t5_first", {l, d}, 33'h0_C0001003);
    // Test 6: ce low masks corners and eof
    @(negedge clk);
    ce = 0; iscorner = 1; frame_eof = 1;
    repeat (20) @(negedge clk);
    check("t6_level", fifo_level, 0);
    check("t6_valid", m_axis_tvalid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
